rtc_write_seq: RTL and testbench
================================

Name: rtc_write_seq

Overview:
- Write-side counterpart of the per-field BCD time/date registers.
- On a commit pulse, it snapshots the six edited BCD fields and checks that each is legal BCD in range.
- It then writes the six fields to the external RTC chip over the multiplexed address/data bus: one address-phase write strobe, then one data-phase write strobe, per field.
- It sits between the field registers (seconds, minutes, hours, day, month, year) and the RTC bus pins.

Parameters:
- T_PH, 4: clock cycles per strobe half-phase (strobe low time = strobe high time = T_PH); legal range 1..255.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- COMMIT  in  1  one-cycle request to write the current field values to the RTC.
- SEG_in  in  8  BCD seconds.
- MIN_in  in  8  BCD minutes.
- HOR_in  in  8  BCD hours, 24 h format.
- DIA_in  in  8  BCD day.
- MES_in  in  8  BCD month.
- ANO_in  in  8  BCD year.
- AD_out  out  8  bus address/data value.
- AD_oe  out  1  bus driver enable.
- A_D  out  1  bus phase: 0 = address phase, 1 = data phase.
- CS_n  out  1  RTC chip select, active low.
- WR_n  out  1  write strobe, active low.
- RD_n  out  1  read strobe; always held 1 by this block.
- BUSY  out  1  high while a write sequence is running.
- DONE  out  1  one-cycle pulse when all six fields have been written.
- ERR  out  1  one-cycle pulse when the snapshot fails validation.

Behaviour:
- Reset (RST=0, asynchronous) forces:
  - CS_n=1, WR_n=1, RD_n=1, AD_oe=0, AD_out=0x00, A_D=0;
  - BUSY=0, DONE=0, ERR=0;
  - state IDLE, field index 0, phase counter 0.
- Reset during a sequence aborts it immediately. No resume after release; the next COMMIT starts a fresh sequence.
- States: IDLE, CHECK, A_LO, A_HI, D_LO, D_HI, GAP, FIN.
- IDLE:
  - COMMIT=1 latches all six inputs into a snapshot and goes to CHECK; BUSY=1 from the next cycle.
  - Later changes on the inputs do not affect the sequence in progress.
- COMMIT while BUSY=1 is ignored (not queued).
- CHECK lasts exactly 1 cycle. Validation rules:
  - every nibble must be ≤9;
  - SEG ≤ 0x59, MIN ≤ 0x59, HOR ≤ 0x23;
  - DIA in 0x01..0x31, MES in 0x01..0x12, ANO in 0x00..0x99.
- CHECK fail: ERR=1 for 1 cycle, BUSY drops in the same cycle, return to IDLE. No bus activity (CS_n stays 1).
- CHECK pass: go to A_LO with field index 0.
- Field order and register addresses:
  - 0 SEG 0x21, 1 MIN 0x22, 2 HOR 0x23, 3 DIA 0x24, 4 MES 0x25, 5 ANO 0x26.
- A_LO (T_PH cycles): CS_n=0, A_D=0, AD_oe=1, AD_out=address, WR_n=0.
- A_HI (T_PH cycles): WR_n=1; address still driven.
- D_LO (T_PH cycles): A_D=1, AD_out=snapshot data, WR_n=0.
- D_HI (T_PH cycles): WR_n=1; data still driven.
- GAP (T_PH cycles): CS_n=1, AD_oe=0, A_D=0.
  - Index <5: increment index, go to A_LO.
  - Index =5: go to FIN.
- FIN lasts 1 cycle: DONE=1, BUSY=0, then IDLE.
- Bus values only change on state edges. AD_out and A_D are stable for the whole time WR_n is low.
- Latency from COMMIT sampled at cycle 0:
  - CHECK at cycle 1;
  - first WR_n fall at cycle 2;
  - each field takes 5·T_PH cycles;
  - DONE at cycle 2+30·T_PH (cycle 122 for T_PH=4).
- Phase counter width is 8 bits. It counts 0..T_PH-1 and is cleared on every state change.
- A COMMIT in the FIN cycle is ignored. A COMMIT in the first IDLE cycle after FIN is accepted.

Decomposition:
- Shared package rtc_pkg holds:
  - RTC register address constants (0x21..0x26);
  - state encoding;
  - BCD range limits per field.
- One sub-module, bcd_check (combinational): inputs value, min, max; output valid. It is instantiated six times in CHECK.

Test Plan:
- COMMIT with SEG=0x45, MIN=0x30, HOR=0x12, DIA=0x15, MES=0x07, ANO=0x24, T_PH=4:
  - bus sees address/data pairs (0x21,0x45), (0x22,0x30), (0x23,0x12), (0x24,0x15), (0x25,0x07), (0x26,0x24), in order;
  - each WR_n low for exactly 4 cycles;
  - DONE at cycle 122; BUSY high in cycles 1..121.
- MES=0x13, all other fields legal → ERR pulse at cycle 1, CS_n never low, DONE never asserted.
- SEG=0x4A → ERR pulse. DIA=0x00 → ERR pulse.
- Second COMMIT at cycle 40 with different inputs → ignored; bus shows only first-snapshot data.
- Change MES_in from 0x07 to 0x08 during the sequence → month written as 0x07.
- RST=0 at cycle 50 mid-write:
  - CS_n=1, WR_n=1, AD_oe=0, BUSY=0 asynchronously;
  - no DONE;
  - a new COMMIT after release restarts at address 0x21.

Source files
------------

// File: rtl/rtc_write_seq_pkg.sv
// Shared definitions for the RTC write sequencer: register map, FSM states
// and the legal BCD range of every time/date field.
package rtc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_A_LO,
        ST_A_HI,
        ST_D_LO,
        ST_D_HI,
        ST_GAP,
        ST_FIN
    } state_t;

    localparam int NUM_FIELDS = 6;

    localparam logic [7:0] ADDR_SEG = 8'h21;
    localparam logic [7:0] ADDR_MIN = 8'h22;
    localparam logic [7:0] ADDR_HOR = 8'h23;
    localparam logic [7:0] ADDR_DIA = 8'h24;
    localparam logic [7:0] ADDR_MES = 8'h25;
    localparam logic [7:0] ADDR_ANO = 8'h26;

    localparam logic [7:0] SEG_LO = 8'h00;
    localparam logic [7:0] SEG_HI = 8'h59;
    localparam logic [7:0] MIN_LO = 8'h00;
    localparam logic [7:0] MIN_HI = 8'h59;
    localparam logic [7:0] HOR_LO = 8'h00;
    localparam logic [7:0] HOR_HI = 8'h23;
    localparam logic [7:0] DIA_LO = 8'h01;
    localparam logic [7:0] DIA_HI = 8'h31;
    localparam logic [7:0] MES_LO = 8'h01;
    localparam logic [7:0] MES_HI = 8'h12;
    localparam logic [7:0] ANO_LO = 8'h00;
    localparam logic [7:0] ANO_HI = 8'h99;

    // Field index order is the order in which fields go out on the bus.
    function automatic logic [7:0] field_addr(input logic [2:0] idx);
        case (idx)
            3'd0:    field_addr = ADDR_SEG;
            3'd1:    field_addr = ADDR_MIN;
            3'd2:    field_addr = ADDR_HOR;
            3'd3:    field_addr = ADDR_DIA;
            3'd4:    field_addr = ADDR_MES;
            default: field_addr = ADDR_ANO;
        endcase
    endfunction

    function automatic logic [7:0] field_min(input logic [2:0] idx);
        case (idx)
            3'd0:    field_min = SEG_LO;
            3'd1:    field_min = MIN_LO;
            3'd2:    field_min = HOR_LO;
            3'd3:    field_min = DIA_LO;
            3'd4:    field_min = MES_LO;
            default: field_min = ANO_LO;
        endcase
    endfunction

    function automatic logic [7:0] field_max(input logic [2:0] idx);
        case (idx)
            3'd0:    field_max = SEG_HI;
            3'd1:    field_max = MIN_HI;
            3'd2:    field_max = HOR_HI;
            3'd3:    field_max = DIA_HI;
            3'd4:    field_max = MES_HI;
            default: field_max = ANO_HI;
        endcase
    endfunction

endpackage

// File: rtl/rtc_write_seq_if.sv
// Multiplexed address/data bus between the write sequencer and the RTC chip.
interface rtc_write_seq_if;

    logic [7:0] AD_out;
    logic       AD_oe;
    logic       A_D;
    logic       CS_n;
    logic       WR_n;
    logic       RD_n;

    modport master (
        output AD_out,
        output AD_oe,
        output A_D,
        output CS_n,
        output WR_n,
        output RD_n
    );

    modport slave (
        input AD_out,
        input AD_oe,
        input A_D,
        input CS_n,
        input WR_n,
        input RD_n
    );

endinterface

// File: rtl/rtc_write_seq_bcd_check.sv
// Combinational legality check of one packed-BCD byte against a BCD range.
module bcd_check (
    input  logic [7:0] value,
    input  logic [7:0] min,
    input  logic [7:0] max,
    output logic       valid
);

    logic digits_ok;

    // Once both digits are legal, binary ordering equals BCD ordering.
    assign digits_ok = (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9);
    assign valid     = digits_ok && (value >= min) && (value <= max);

endmodule

// File: rtl/rtc_write_seq.sv
// Snapshots the six BCD time/date fields on COMMIT, validates them, and
// writes them to the RTC as address-strobe / data-strobe pairs.
module rtc_write_seq
    import rtc_pkg::*;
#(
    parameter int T_PH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       COMMIT,
    input  logic [7:0] SEG_in,
    input  logic [7:0] MIN_in,
    input  logic [7:0] HOR_in,
    input  logic [7:0] DIA_in,
    input  logic [7:0] MES_in,
    input  logic [7:0] ANO_in,
    rtc_write_seq_if.master bus,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    localparam logic [7:0] PH_LAST   = 8'(T_PH - 1);
    localparam logic [2:0] LAST_FIELD = 3'(NUM_FIELDS - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] phase_cnt;
    logic [2:0] index;
    logic [7:0] snap [NUM_FIELDS];
    logic [NUM_FIELDS-1:0] field_ok;
    logic       all_valid;
    logic       timer_done;

    for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_chk
        bcd_check u_chk (
            .value (snap[g]),
            .min   (field_min(3'(g))),
            .max   (field_max(3'(g))),
            .valid (field_ok[g])
        );
    end

    assign all_valid  = &field_ok;
    assign timer_done = (phase_cnt == PH_LAST);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Phase counter only runs inside the timed bus states and restarts on
    // every state change, so each of those states lasts exactly T_PH cycles.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            phase_cnt <= 8'd0;
            index     <= 3'd0;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                snap[i] <= 8'h00;
            end
        end else begin
            if (next_state != state) begin
                phase_cnt <= 8'd0;
            end else if (state inside {ST_A_LO, ST_A_HI, ST_D_LO, ST_D_HI, ST_GAP}) begin
                phase_cnt <= phase_cnt + 8'd1;
            end

            if (state == ST_CHECK) begin
                index <= 3'd0;
            end else if (state == ST_GAP && timer_done && index != LAST_FIELD) begin
                index <= index + 3'd1;
            end

            if (state == ST_IDLE && COMMIT) begin
                snap[0] <= SEG_in;
                snap[1] <= MIN_in;
                snap[2] <= HOR_in;
                snap[3] <= DIA_in;
                snap[4] <= MES_in;
                snap[5] <= ANO_in;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (COMMIT) next_state = ST_CHECK;
            ST_CHECK: next_state = all_valid ? ST_A_LO : ST_IDLE;
            ST_A_LO:  if (timer_done) next_state = ST_A_HI;
            ST_A_HI:  if (timer_done) next_state = ST_D_LO;
            ST_D_LO:  if (timer_done) next_state = ST_D_HI;
            ST_D_HI:  if (timer_done) next_state = ST_GAP;
            ST_GAP: begin
                if (timer_done) begin
                    next_state = (index == LAST_FIELD) ? ST_FIN : ST_A_LO;
                end
            end
            ST_FIN:   next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Bus pins are a pure decode of the registered state, index and snapshot,
    // so they can only move on state edges.
    always_comb begin
        bus.AD_out = 8'h00;
        bus.AD_oe  = 1'b0;
        bus.A_D    = 1'b0;
        bus.CS_n   = 1'b1;
        bus.WR_n   = 1'b1;
        bus.RD_n   = 1'b1;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        ERR        = 1'b0;
        case (state)
            ST_CHECK: begin
                BUSY = all_valid;
                ERR  = !all_valid;
            end
            ST_A_LO, ST_A_HI: begin
                bus.CS_n   = 1'b0;
                bus.AD_oe  = 1'b1;
                bus.AD_out = field_addr(index);
                bus.WR_n   = (state == ST_A_HI);
                BUSY       = 1'b1;
            end
            ST_D_LO, ST_D_HI: begin
                bus.CS_n   = 1'b0;
                bus.AD_oe  = 1'b1;
                bus.A_D    = 1'b1;
                bus.AD_out = snap[index];
                bus.WR_n   = (state == ST_D_HI);
                BUSY       = 1'b1;
            end
            ST_GAP: begin
                BUSY = 1'b1;
            end
            ST_FIN: begin
                DONE = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_rtc_write_seq.sv
// Directed self-checking bench for rtc_write_seq: vector table plus
// hand-written sequences for ignored COMMITs, input changes and reset abort.
module tb_rtc_write_seq;

    localparam int T_PH     = 4;
    localparam int DONE_REL = 2 + 30 * T_PH;

    logic       CLK;
    logic       RST;
    logic       COMMIT;
    logic [7:0] SEG_in, MIN_in, HOR_in, DIA_in, MES_in, ANO_in;
    logic       BUSY, DONE, ERR;

    rtc_write_seq_if bus_if ();

    rtc_write_seq #(.T_PH(T_PH)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .COMMIT (COMMIT),
        .SEG_in (SEG_in),
        .MIN_in (MIN_in),
        .HOR_in (HOR_in),
        .DIA_in (DIA_in),
        .MES_in (MES_in),
        .ANO_in (ANO_in),
        .bus    (bus_if),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .ERR    (ERR)
    );

    typedef struct {
        logic [7:0] seg, mnt, hor, dia, mes, ano;
        bit         exp_err;
    } vec_t;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int t0 = 0;

    logic [8:0] wr_q [$];
    int         fall_q [$];
    int         len_q [$];
    logic [8:0] held;
    logic       prev_wr;
    int         low_len, unstable, done_cnt, done_cyc, err_cnt, err_cyc;
    int         busy_cnt, busy_first, busy_last;
    bit         cs_low_seen;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Bus recorder: logs every WR_n strobe with its value, start cycle and width.
    always @(negedge CLK) begin
        if (!bus_if.WR_n && prev_wr) begin
            held = {bus_if.A_D, bus_if.AD_out};
            wr_q.push_back(held);
            fall_q.push_back(cyc - t0);
            low_len = 1;
        end else if (!bus_if.WR_n) begin
            low_len++;
            if ({bus_if.A_D, bus_if.AD_out} != held) unstable++;
        end
        if (bus_if.WR_n && !prev_wr) len_q.push_back(low_len);
        if (!bus_if.CS_n) cs_low_seen = 1'b1;
        if (DONE) begin done_cnt++; done_cyc = cyc - t0; end
        if (ERR) begin err_cnt++; err_cyc = cyc - t0; end
        if (BUSY) begin
            if (busy_cnt == 0) busy_first = cyc - t0;
            busy_last = cyc - t0;
            busy_cnt++;
        end
        prev_wr = bus_if.WR_n;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearMon();
        wr_q.delete();
        fall_q.delete();
        len_q.delete();
        prev_wr = 1'b1;
        low_len = 0; unstable = 0;
        done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
        busy_cnt = 0; busy_first = -1; busy_last = -1;
        cs_low_seen = 1'b0;
    endtask

    task automatic stepCycle();
        @(negedge CLK);
        #1;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic waitRel(input int n);
        while (cyc - t0 < n) stepCycle();
    endtask

    task automatic applyStimulus(input vec_t v);
        SEG_in = v.seg; MIN_in = v.mnt; HOR_in = v.hor;
        DIA_in = v.dia; MES_in = v.mes; ANO_in = v.ano;
    endtask

    // Starts a new measured sequence: COMMIT is high for one cycle (cycle 0).
    task automatic pulseCommit();
        stepCycle();
        clearMon();
        t0 = cyc;
        COMMIT = 1'b1;
        stepCycle();
        COMMIT = 1'b0;
    endtask

    task automatic waitEnd(input int budget);
        int n = 0;
        while (done_cnt == 0 && err_cnt == 0 && n < budget) begin
            stepCycle();
            n++;
        end
        checkOutput("end_event", done_cnt + err_cnt, 1);
        waitCycles(3);
    endtask

    task automatic checkWrites(input string tag, input vec_t v);
        logic [7:0] exp_data [6];
        int bad_len = 0;
        exp_data = '{v.seg, v.mnt, v.hor, v.dia, v.mes, v.ano};
        checkOutput({tag, "_strobes"}, wr_q.size(), 12);
        if (wr_q.size() == 12 && fall_q.size() == 12) begin
            for (int f = 0; f < 6; f++) begin
                checkOutput($sformatf("%s_addr%0d", tag, f), int'(wr_q[2*f]), int'({1'b0, 8'h21 + 8'(f)}));
                checkOutput($sformatf("%s_data%0d", tag, f), int'(wr_q[2*f+1]), int'({1'b1, exp_data[f]}));
                checkOutput($sformatf("%s_afall%0d", tag, f), fall_q[2*f], 2 + 5*T_PH*f);
                checkOutput($sformatf("%s_dfall%0d", tag, f), fall_q[2*f+1], 2 + 5*T_PH*f + 2*T_PH);
            end
        end
        foreach (len_q[i]) if (len_q[i] != T_PH) bad_len++;
        checkOutput({tag, "_bad_wr_len"}, bad_len, 0);
        checkOutput({tag, "_unstable"}, unstable, 0);
        checkOutput({tag, "_done_cnt"}, done_cnt, 1);
        checkOutput({tag, "_done_cyc"}, done_cyc, DONE_REL);
        checkOutput({tag, "_err_cnt"}, err_cnt, 0);
        checkOutput({tag, "_busy_first"}, busy_first, 1);
        checkOutput({tag, "_busy_last"}, busy_last, DONE_REL - 1);
        checkOutput({tag, "_busy_cnt"}, busy_cnt, DONE_REL - 1);
    endtask

    task automatic checkRejected(input string tag);
        checkOutput({tag, "_err_cnt"}, err_cnt, 1);
        checkOutput({tag, "_err_cyc"}, err_cyc, 1);
        checkOutput({tag, "_cs_low"}, int'(cs_low_seen), 0);
        checkOutput({tag, "_done_cnt"}, done_cnt, 0);
        checkOutput({tag, "_busy_cnt"}, busy_cnt, 0);
        checkOutput({tag, "_strobes"}, wr_q.size(), 0);
    endtask

    initial begin
        vec_t vec [8];
        vec_t main_v;
        vec_t other_v;
        vec[0] = '{8'h45, 8'h30, 8'h12, 8'h15, 8'h07, 8'h24, 1'b0};
        vec[1] = '{8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99, 1'b0};
        vec[2] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 1'b0};
        vec[3] = '{8'h45, 8'h30, 8'h12, 8'h15, 8'h13, 8'h24, 1'b1};
        vec[4] = '{8'h4A, 8'h30, 8'h12, 8'h15, 8'h07, 8'h24, 1'b1};
        vec[5] = '{8'h45, 8'h30, 8'h12, 8'h00, 8'h07, 8'h24, 1'b1};
        vec[6] = '{8'h45, 8'h30, 8'h24, 8'h15, 8'h07, 8'h24, 1'b1};
        vec[7] = '{8'h45, 8'h60, 8'h12, 8'h15, 8'h07, 8'h9A, 1'b1};
        main_v  = vec[0];
        other_v = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h08, 8'h11, 1'b0};

        COMMIT = 1'b0;
        applyStimulus(main_v);
        clearMon();
        RST = 1'b0;
        #2;
        checkOutput("rst_CS_n", int'(bus_if.CS_n), 1);
        checkOutput("rst_WR_n", int'(bus_if.WR_n), 1);
        checkOutput("rst_RD_n", int'(bus_if.RD_n), 1);
        checkOutput("rst_AD_oe", int'(bus_if.AD_oe), 0);
        checkOutput("rst_AD_out", int'(bus_if.AD_out), 0);
        checkOutput("rst_A_D", int'(bus_if.A_D), 0);
        checkOutput("rst_flags", int'({BUSY, DONE, ERR}), 0);
        #20;
        RST = 1'b1;
        waitCycles(2);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vec[i]);
            pulseCommit();
            waitEnd(DONE_REL + 20);
            if (vec[i].exp_err) checkRejected($sformatf("vec%0d", i));
            else checkWrites($sformatf("vec%0d", i), vec[i]);
            checkOutput($sformatf("vec%0d_RD_n", i), int'(bus_if.RD_n), 1);
        end

        // COMMIT at cycle 40 with new inputs (MES now 0x08) must not disturb the write.
        applyStimulus(main_v);
        pulseCommit();
        waitRel(40);
        applyStimulus(other_v);
        COMMIT = 1'b1;
        stepCycle();
        COMMIT = 1'b0;
        waitEnd(DONE_REL + 20);
        checkWrites("ignore", main_v);

        // Reset at cycle 50 aborts asynchronously; next COMMIT restarts at 0x21.
        applyStimulus(main_v);
        pulseCommit();
        waitRel(50);
        checkOutput("pre_rst_CS_n", int'(bus_if.CS_n), 0);
        RST = 1'b0;
        #1;
        checkOutput("abort_CS_n", int'(bus_if.CS_n), 1);
        checkOutput("abort_WR_n", int'(bus_if.WR_n), 1);
        checkOutput("abort_AD_oe", int'(bus_if.AD_oe), 0);
        checkOutput("abort_BUSY", int'(BUSY), 0);
        waitCycles(3);
        RST = 1'b1;
        waitCycles(DONE_REL);
        checkOutput("abort_done_cnt", done_cnt, 0);
        pulseCommit();
        waitEnd(DONE_REL + 20);
        checkWrites("restart", main_v);

        // COMMIT in the FIN cycle is dropped.
        pulseCommit();
        waitRel(DONE_REL);
        COMMIT = 1'b1;
        stepCycle();
        COMMIT = 1'b0;
        waitCycles(6);
        checkOutput("fin_commit_busy_cnt", busy_cnt, DONE_REL - 1);
        checkOutput("fin_commit_done_cnt", done_cnt, 1);

        // COMMIT in the first IDLE cycle after FIN starts a new sequence.
        pulseCommit();
        waitRel(DONE_REL + 1);
        clearMon();
        t0 = cyc;
        COMMIT = 1'b1;
        stepCycle();
        COMMIT = 1'b0;
        waitEnd(DONE_REL + 20);
        checkWrites("post_fin", main_v);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
